// File: rtl/cgra_control_exec_mc.sv
// Multi-channel CGRA execution controller: fetch, wait-for-data, process, drain, done.
// Optional performance counters are enabled by defining CGRA_EXEC_PERF_CNT_EN.
module cgra_control_exec_mc #(
    parameter int unsigned NUM_RD = 4,
    parameter int unsigned NUM_WR = 4,
    parameter int unsigned EN_LAT = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_RD-1:0] read_fifo_mask,
    input  logic [NUM_WR-1:0] write_fifo_mask,
    input  logic [NUM_RD-1:0] available_read,
    input  logic [NUM_WR-1:0] available_write,
    input  logic [NUM_RD-1:0] available_pop,
    input  logic [NUM_WR-1:0] available_push,
    input  logic [NUM_RD-1:0] read_fifo_done,
    input  logic [NUM_WR-1:0] write_fifo_done,
    output logic              en,
    output logic [NUM_RD-1:0] en_fetch_data,
    output logic              done,
    output logic              busy,
    output logic              aborted
`ifdef CGRA_EXEC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  run_cycles,
    output logic [CNT_W-1:0]  stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_PROCESS,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_RD-1:0]   r_rmask;
    logic [NUM_WR-1:0]   r_wmask;
    logic                r_queues_ok;
    logic [EN_LAT-1:0]   r_en_pipe;
    logic [3:0]          r_drain_cnt;
    logic                w_abort;
    logic                w_fire;
    logic                w_proc_exit;
    logic                w_drain_last;
    logic                w_launch;
    logic [NUM_RD-1:0]   w_qmask_r;
    logic [NUM_WR-1:0]   w_qmask_w;

    assign w_abort      = abort & (r_state != S_IDLE);
    assign w_fire       = (r_state == S_PROCESS)
                        & (&(available_read  | read_fifo_done  | ~r_rmask))
                        & (&(available_write | write_fifo_done | ~r_wmask));
    assign w_proc_exit  = (r_wmask == '0) ? &(read_fifo_done  | ~r_rmask)
                                          : &(write_fifo_done | ~r_wmask);
    assign w_drain_last = (r_drain_cnt == 4'(EN_LAT - 1));
    assign w_launch     = (r_state == S_IDLE) && (w_state_nxt == S_WAIT_DATA);

    // In IDLE the queue check looks at the masks about to be captured, so the
    // first WAIT_DATA cycle never sees a stale result from the previous run.
    assign w_qmask_r = (r_state == S_IDLE) ? read_fifo_mask  : r_rmask;
    assign w_qmask_w = (r_state == S_IDLE) ? write_fifo_mask : r_wmask;

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_state_nxt = ((read_fifo_mask != '0) || (write_fifo_mask != '0))
                                               ? S_WAIT_DATA : S_DONE;
                S_WAIT_DATA: if (r_queues_ok) w_state_nxt = S_PROCESS;
                S_PROCESS:   if (w_proc_exit) w_state_nxt = S_DRAIN;
                S_DRAIN:     if (w_drain_last) w_state_nxt = S_DONE;
                S_DONE:      if (!start) w_state_nxt = S_IDLE;
                default:     w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rmask       <= '0;
            r_wmask       <= '0;
            r_queues_ok   <= 1'b0;
            r_en_pipe     <= '0;
            r_drain_cnt   <= '0;
            en_fetch_data <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
            aborted       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_queues_ok <= (&(available_pop | ~w_qmask_r)) & (&(available_push | ~w_qmask_w));
            if (w_launch) begin
                r_rmask <= read_fifo_mask;
                r_wmask <= write_fifo_mask;
            end else if (w_state_nxt == S_IDLE) begin
                r_rmask <= '0;
                r_wmask <= '0;
            end
            if (w_abort) r_en_pipe <= '0;
            else         r_en_pipe <= (r_en_pipe << 1) | EN_LAT'(w_fire);
            if ((r_state == S_DRAIN) && !w_abort) r_drain_cnt <= r_drain_cnt + 4'd1;
            else                                  r_drain_cnt <= '0;
            if (w_launch)
                en_fetch_data <= read_fifo_mask;
            else if ((w_state_nxt == S_DONE) || (w_state_nxt == S_IDLE))
                en_fetch_data <= '0;
            done    <= (w_state_nxt == S_DONE);
            busy    <= (w_state_nxt == S_WAIT_DATA) || (w_state_nxt == S_PROCESS)
                    || (w_state_nxt == S_DRAIN);
            aborted <= w_abort;
        end
    end

    assign en = r_en_pipe[EN_LAT-1];

`ifdef CGRA_EXEC_PERF_CNT_EN
    logic [CNT_W-1:0] r_run_cycles;
    logic [CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cycles   <= '0;
            r_stall_cycles <= '0;
        end else if (w_launch) begin
            r_run_cycles   <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (((r_state == S_PROCESS) || (r_state == S_DRAIN)) && (r_run_cycles != '1))
                r_run_cycles <= r_run_cycles + 1'b1;
            if ((r_state == S_PROCESS) && !w_fire && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign run_cycles   = r_run_cycles;
    assign stall_cycles = r_stall_cycles;
`else
    // Counters compiled out; CNT_W only sizes them.
    if (CNT_W == 0) begin : g_no_perf
    end
`endif

endmodule

// File: tb/tb_cgra_control_exec_mc.sv
// Randomised scoreboard bench for cgra_control_exec_mc with a run-level timeline model.
module tb_cgra_control_exec_mc;
    localparam int unsigned NR  = 4;
    localparam int unsigned NW  = 4;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [NR-1:0] read_fifo_mask, available_read, available_pop, read_fifo_done;
    logic [NW-1:0] write_fifo_mask, available_write, available_push, write_fifo_done;
    logic          en, done, busy, aborted;
    logic [NR-1:0] en_fetch_data;
`ifdef CGRA_EXEC_PERF_CNT_EN
    logic [31:0]   run_cycles, stall_cycles;
`endif

    cgra_control_exec_mc #(.NUM_RD(NR), .NUM_WR(NW), .EN_LAT(LAT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .read_fifo_mask(read_fifo_mask), .write_fifo_mask(write_fifo_mask),
        .available_read(available_read), .available_write(available_write),
        .available_pop(available_pop), .available_push(available_push),
        .read_fifo_done(read_fifo_done), .write_fifo_done(write_fifo_done),
        .en(en), .en_fetch_data(en_fetch_data), .done(done), .busy(busy), .aborted(aborted)
`ifdef CGRA_EXEC_PERF_CNT_EN
        , .run_cycles(run_cycles), .stall_cycles(stall_cycles)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          en;
        logic [NR-1:0] fetch;
        logic          done;
        logic          busy;
        logic          aborted;
        bit            chk_perf;
        int            run;
        int            stall;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("en", e.cyc, 32'(en), 32'(e.en));
                check("en_fetch_data", e.cyc, 32'(en_fetch_data), 32'(e.fetch));
                check("done", e.cyc, 32'(done), 32'(e.done));
                check("busy", e.cyc, 32'(busy), 32'(e.busy));
                check("aborted", e.cyc, 32'(aborted), 32'(e.aborted));
`ifdef CGRA_EXEC_PERF_CNT_EN
                if (e.chk_perf) begin
                    check("run_cycles", e.cyc, run_cycles, 32'(e.run));
                    check("stall_cycles", e.cyc, stall_cycles, 32'(e.stall));
                end
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t idle_exp(input int c, input logic ab);
        exp_t e;
        e.cyc = c; e.en = 1'b0; e.fetch = '0; e.done = 1'b0; e.busy = 1'b0;
        e.aborted = ab; e.chk_perf = 1'b0; e.run = 0; e.stall = 0;
        return e;
    endfunction

    task automatic do_gap();
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
            @(posedge clk); #1; cyc++;
            start = 1'b0; abort = 1'(($urandom));
            read_fifo_mask = NR'($urandom); write_fifo_mask = NW'($urandom);
            available_read = NR'($urandom); available_write = NW'($urandom);
            available_pop = NR'($urandom); available_push = NW'($urandom);
            read_fifo_done = NR'($urandom); write_fifo_done = NW'($urandom);
            q.push_back(idle_exp(cyc, 1'b0));
        end
    endtask

    // A run is described by its phase boundaries; every output follows from them.
    task automatic do_run();
        logic [NR-1:0] rm;
        logic [NW-1:0] wm;
        bit byp, ab;
        bit stall[16];
        int s, p, l, h, a, p0, done0, last, nst, k, kk;
        exp_t e;
        byp = ($urandom_range(0, 5) == 0);
        if (byp) begin
            rm = '0; wm = '0;
        end else begin
            do begin
                rm = NR'($urandom); wm = NW'($urandom);
            end while (rm == '0 && wm == '0);
        end
        p = $urandom_range(0, 3);
        l = $urandom_range(1, 12);
        h = $urandom_range(0, 3);
        ab = ($urandom_range(0, 3) == 0);
        nst = 0;
        for (int i = 0; i < 16; i++) begin
            stall[i] = (i < l - 1) && ($urandom_range(0, 2) == 0);
            if (stall[i]) nst++;
        end
        s     = cyc + 1;
        p0    = byp ? (1 << 30) : s + p + 2;
        done0 = byp ? s + 1 : p0 + l + int'(LAT);
        last  = done0 + h;
        a     = -1;
        if (ab) begin
            a = $urandom_range(s + 1, last);
            last = a + 1;
        end
        for (int c = s; c <= last; c++) begin
            @(posedge clk); #1; cyc = c;
            start = (c == s) || (!(ab && c > a) && c >= done0 && c < done0 + h);
            abort = (c == s) ? 1'(($urandom)) : (ab && c == a);
            read_fifo_mask  = (c == s) ? rm : NR'($urandom);
            write_fifo_mask = (c == s) ? wm : NW'($urandom);
            available_pop   = (c < s + p) ? (NR'($urandom) & ~rm) : (NR'($urandom) | rm);
            available_push  = (c < s + p) ? (NW'($urandom) & ~wm) : (NW'($urandom) | wm);
            available_read  = NR'($urandom) | rm;
            available_write = NW'($urandom) | wm;
            k = c - p0;
            if (k >= 0 && k < l && stall[k]) begin
                if (rm != '0) available_read  = available_read  & ~(rm & (~rm + 1'b1));
                else          available_write = available_write & ~(wm & (~wm + 1'b1));
            end
            read_fifo_done  = (c >= p0 + l - 1) ? '1 : (NR'($urandom) & ~rm);
            write_fifo_done = (c >= p0 + l - 1) ? '1 : (NW'($urandom) & ~wm);
            if (ab && c > a) begin
                e = idle_exp(c, c == a + 1);
            end else begin
                e = idle_exp(c, 1'b0);
                e.busy  = !byp && c > s && c < done0;
                e.fetch = e.busy ? rm : '0;
                e.done  = (c >= done0) && (c <= done0 + h);
                kk = c - int'(LAT) - p0;
                e.en = !byp && kk >= 0 && kk < l && !stall[kk];
                e.chk_perf = !byp && !ab && e.done;
                e.run = l + int'(LAT);
                e.stall = nst;
            end
            q.push_back(e);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, cyc, 32'(en), 32'd0);
        check({tag, "_fetch"}, cyc, 32'(en_fetch_data), 32'd0);
        check({tag, "_done"}, cyc, 32'(done), 32'd0);
        check({tag, "_busy"}, cyc, 32'(busy), 32'd0);
        check({tag, "_aborted"}, cyc, 32'(aborted), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        read_fifo_mask = '0; write_fifo_mask = '0;
        available_read = '0; available_write = '0;
        available_pop = '0; available_push = '0;
        read_fifo_done = '0; write_fifo_done = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 60; r++) begin
            do_gap();
            do_run();
        end
        @(posedge clk); #1; cyc++;
        start = 1'b0; abort = 1'b0;
        q.push_back(idle_exp(cyc, 1'b0));
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of PROCESS.
        @(posedge clk); #1; cyc++;
        read_fifo_mask = 4'b0011; write_fifo_mask = 4'b0001;
        available_pop = '1; available_push = '1;
        available_read = '1; available_write = '1;
        read_fifo_done = '0; write_fifo_done = '0;
        start = 1'b1;
        @(posedge clk); #1; cyc++; start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1; cyc++;
        end
        check("pre_rst_busy", cyc, 32'(busy), 32'd1);
        check("pre_rst_en", cyc, 32'(en), 32'd1);
        check("pre_rst_fetch", cyc, 32'(en_fetch_data), 32'h3);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk); cyc++;
            check_all_zero("post_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cgra_control_exec_mc.md
Name: cgra_control_exec_mc

Overview:
- Parametrised multi-channel execution controller for a CGRA accelerator, sitting between the input/output FIFO controllers and the CGRA datapath.
- Accepts NUM_RD read channels and NUM_WR write channels, each independently masked.
- Sequences fetch, wait-for-data, process, pipeline drain and done; generates the datapath enable with configurable latency.
- Adds abort, re-arm after done, and an all-masked bypass.

Parameters:
- NUM_RD, 4, number of read (input) FIFO channels, 1..32
- NUM_WR, 4, number of write (output) FIFO channels, 1..32
- EN_LAT, 2, register stages from fire condition to en output, 1..8
- CNT_W, 32, width of performance counters (optional feature only)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; run request
- abort  in  1  synchronous abort request
- read_fifo_mask  in  NUM_RD  1 = read channel participates
- write_fifo_mask  in  NUM_WR  1 = write channel participates
- available_read  in  NUM_RD  read FIFO can supply a word this cycle
- available_write  in  NUM_WR  write FIFO can accept a word this cycle
- available_pop  in  NUM_RD  read queue holds enough data to begin
- available_push  in  NUM_WR  write queue holds enough space to begin
- read_fifo_done  in  NUM_RD  read channel exhausted
- write_fifo_done  in  NUM_WR  write channel finished
- en  out  1  datapath enable
- en_fetch_data  out  NUM_RD  per-channel fetch enable to the read FIFO controllers
- done  out  1  run complete
- busy  out  1  state is WAIT_DATA, PROCESS or DRAIN
- aborted  out  1  one-cycle pulse on abort acceptance

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE; all outputs 0; mask registers 0; en pipeline 0.
- Masks: rmask/wmask are captured from the mask ports on the IDLE->WAIT_DATA edge and held until IDLE is re-entered. Mask port changes mid-run are ignored.
- queues_ok: registered signal, 1-cycle latency:
  - &(available_pop | ~rmask) & &(available_push | ~wmask).
- fire: combinational.
  - fire = (state==PROCESS) & &(available_read | read_fifo_done | ~rmask) & &(available_write | write_fifo_done | ~wmask).
  - All participating channels must be ready. This is an AND, not an OR.
- en: fire delayed by exactly EN_LAT cycles through a shift register.
  - Abort clears the whole shift register on the same edge.
- States (encoding free):
  - IDLE:
    - start=1 and (mask ports not all zero) -> WAIT_DATA; en_fetch_data <= read_fifo_mask.
    - start=1 and both mask ports all zero -> DONE directly.
  - WAIT_DATA: queues_ok=1 -> PROCESS.
  - PROCESS: &(write_fifo_done | ~wmask) -> DRAIN.
    - If wmask is 0, the exit condition is instead &(read_fifo_done | ~rmask).
  - DRAIN: fire forced 0; count EN_LAT cycles so in-flight en pulses emerge; then -> DONE.
  - DONE: done=1, en_fetch_data=0. start=0 -> IDLE, done cleared on that edge (re-arm). Start held high keeps DONE.
- abort:
  - Highest priority.
  - In any state except IDLE: next state IDLE; en_fetch_data=0; en pipe flushed; aborted=1 for one cycle; done=0.
  - abort in IDLE: ignored, no pulse.
- Simultaneous events:
  - start and abort in IDLE -> start wins (abort ignored in IDLE).
  - write done in the same cycle as fire -> that fire still propagates to en.
- busy is a registered decode of state.

Optional Feature:
- Macro: CGRA_EXEC_PERF_CNT_EN.
- When defined, adds two outputs:
  - run_cycles [CNT_W]: counts cycles in PROCESS or DRAIN.
  - stall_cycles [CNT_W]: counts PROCESS cycles with fire=0.
- Counter rules:
  - Both cleared on the IDLE->WAIT_DATA edge.
  - Both saturate at all-ones.
  - Both hold in DONE; both cleared by reset.
  - Abort does not clear them.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- NUM_RD=NUM_WR=4, EN_LAT=2, masks 4'b0011/4'b0001, pop/push ready, all available, start -> en_fetch_data=4'b0011 one cycle after start, en first high EN_LAT cycles after PROCESS entry. Then write_fifo_done[0]=1 -> DRAIN 2 cycles, done=1, busy=0.
- Same setup, available_read[1]=0 for 5 PROCESS cycles -> en low for exactly those 5 cycles (shifted by 2); unmasked channel 2 toggling has no effect.
- Abort asserted mid-PROCESS with en pipe full -> next edge state IDLE, en=0 immediately, aborted pulse width 1, done=0.
- Both masks 0, start=1 -> done=1 next cycle, en never asserted. Drop start -> done=0, IDLE. Re-assert start with valid masks -> full run completes.
- rst_n low asynchronously during PROCESS (between edges) -> en, done, busy, en_fetch_data 0 immediately. After release, no activity until start.
- With CGRA_EXEC_PERF_CNT_EN, 10 PROCESS cycles including 3 stalls, EN_LAT=2 -> run_cycles=12, stall_cycles=3 in DONE.
